// File: rtl/minterm_extractor_if.sv
// ============================================================================
//  Module      : minterm_extractor_if
//  Description : Host/consumer bundle for minterm_extractor. Carries the
//                start/truth-table request, the status flags and the
//                valid/ready minterm output stream.
//                master : host + downstream consumer (drives start,
//                         truth_table, m_ready)
//                slave  : the extractor (drives busy, m_valid, m_index,
//                         m_last, done, count)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface minterm_extractor_if #(
    parameter int N_VARS = 4
);
    localparam int c_tbl_w = 2 ** N_VARS;

    logic                 start;
    logic [c_tbl_w-1:0]   truth_table;
    logic                 busy;
    logic                 m_valid;
    logic                 m_ready;
    logic [N_VARS-1:0]    m_index;
    logic                 m_last;
    logic                 done;
    logic [N_VARS:0]      count;

    modport master (
        output start, truth_table, m_ready,
        input  busy, m_valid, m_index, m_last, done, count
    );

    modport slave (
        input  start, truth_table, m_ready,
        output busy, m_valid, m_index, m_last, done, count
    );
endinterface

`default_nettype wire

// File: rtl/minterm_extractor.sv
// ============================================================================
//  Module      : minterm_extractor
//  Description : Takes a 2**N_VARS-bit truth table and serially emits the
//                index of every set bit (minterm) in ascending order over a
//                valid/ready stream. One table bit is examined per clock.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                s_if   - slave side of minterm_extractor_if:
//                         start/truth_table in, busy/done/count status out,
//                         m_valid/m_index/m_last out with m_ready in
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minterm_extractor #(
    parameter int N_VARS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    minterm_extractor_if.slave s_if
);

    localparam int                c_tbl_w   = 2 ** N_VARS;
    localparam logic [N_VARS-1:0] c_max_idx = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [N_VARS-1:0]    r_idx;
    logic [c_tbl_w-1:0]   r_tbl;
    logic                 r_busy;
    logic                 r_valid;
    logic [N_VARS-1:0]    r_index;
    logic                 r_last;
    logic                 r_done;
    logic [N_VARS:0]      r_count;

    // The shift amount is one bit wider than the index so that idx+1 at the
    // top index shifts the whole table out instead of wrapping to zero.
    logic [N_VARS:0]      w_shamt;
    logic [c_tbl_w-1:0]   w_upper;
    logic                 w_last;

    assign w_shamt = {1'b0, r_idx} + {{N_VARS{1'b0}}, 1'b1};
    assign w_upper = r_tbl >> w_shamt;
    assign w_last  = (w_upper == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tbl   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_index <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            // done is a single-cycle pulse; only the terminating edge sets it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // busy is always low here, so a start seen while busy
                    // (including on the terminating edge) never gets here.
                    if (s_if.start) begin
                        r_tbl   <= s_if.truth_table;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (r_tbl[r_idx]) begin
                        r_index <= r_idx;
                        r_last  <= w_last;
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end else if (r_idx == c_max_idx) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (r_valid && s_if.m_ready) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + 1'b1;
                        if (r_last) begin
                            // The top index always lands here with r_last set,
                            // so r_idx is never incremented past it.
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_if.busy    = r_busy;
    assign s_if.m_valid = r_valid;
    assign s_if.m_index = r_index;
    assign s_if.m_last  = r_last;
    assign s_if.done    = r_done;
    assign s_if.count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_minterm_extractor.sv
// ============================================================================
//  Module      : tb_minterm_extractor
//  Description : Scoreboard bench for minterm_extractor. The driver pushes
//                the expected minterm list and final count for every start
//                it expects to be accepted; a negedge monitor pops and
//                compares on every handshake and done pulse, and checks
//                output stability under back-pressure and edge latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minterm_extractor;

    localparam int N  = 4;
    localparam int TW = 2 ** N;

    typedef struct {
        int idx;
        int last;
    } exp_t;

    logic clk;
    logic rst_n;

    minterm_extractor_if #(.N_VARS(N)) bus ();

    minterm_extractor #(.N_VARS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q_exp[$];
    int   q_done[$];

    int   ready_mode = 0;   // 0 high, 1 random, 2 stall on index 2, 3 low
    int   stall_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: every set bit in ascending order; the last one is the
    // highest set bit of the table.
    task automatic model_push(input logic [TW-1:0] tt);
        int   hi;
        int   n;
        exp_t e;
        hi = -1;
        n  = 0;
        for (int k = 0; k < TW; k++) if (tt[k]) hi = k;
        for (int k = 0; k < TW; k++) begin
            if (tt[k]) begin
                e.idx  = k;
                e.last = (k == hi) ? 1 : 0;
                q_exp.push_back(e);
                n++;
            end
        end
        q_done.push_back(n);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.m_valid && bus.m_index == 4'd2 && stall_cnt < 5) begin
                        bus.m_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.m_ready = 1'b1;
                    end
                end
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic       prev_hold  = 1'b0;
    int         prev_idx   = 0;
    int         prev_last  = 0;
    int         last_event = 0;
    int         last_idx   = -1;
    int         start_edge = 0;
    int         hs_cnt     = 0;

    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", int'(bus.m_valid), 1);
                check("hold_index", int'(bus.m_index), prev_idx);
                check("hold_last",  int'(bus.m_last),  prev_last);
            end else if (bus.m_valid) begin
                // New minterm: edges since start/previous handshake equal
                // the index distance.
                check("latency", cyc - last_event, int'(bus.m_index) - last_idx);
            end

            if (bus.m_valid && bus.m_ready) begin
                if (q_exp.size() == 0) begin
                    fail_now("unexpected_minterm");
                end else begin
                    e = q_exp.pop_front();
                    check("m_index", int'(bus.m_index), e.idx);
                    check("m_last",  int'(bus.m_last),  e.last);
                end
                last_event = cyc + 1;
                last_idx   = int'(bus.m_index);
                hs_cnt++;
            end

            prev_hold = bus.m_valid && !bus.m_ready;
            prev_idx  = int'(bus.m_index);
            prev_last = int'(bus.m_last);

            if (bus.done) begin
                if (q_done.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    ec = q_done.pop_front();
                    check("count",      int'(bus.count), ec);
                    check("handshakes", hs_cnt, ec);
                    check("done_busy",  int'(bus.busy), 0);
                    check("done_time",  cyc, (ec == 0) ? start_edge + TW : last_event);
                end
            end

            // A start seen with busy low is taken on the coming edge.
            if (bus.start && !bus.busy) begin
                start_edge = cyc + 1;
                last_event = cyc + 1;
                last_idx   = -1;
                hs_cnt     = 0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [TW-1:0] tt);
        bus.start       = 1'b1;
        bus.truth_table = tt;
        model_push(tt);
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.truth_table = TW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) fail_now("timeout_wait_idle");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    int'(bus.busy),    0);
        check({tag, "_m_valid"}, int'(bus.m_valid), 0);
        check({tag, "_m_index"}, int'(bus.m_index), 0);
        check({tag, "_m_last"},  int'(bus.m_last),  0);
        check({tag, "_done"},    int'(bus.done),    0);
        check({tag, "_count"},   int'(bus.count),   0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int            n;
        logic [TW-1:0] tt;

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.truth_table = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed tables with the consumer always ready
        ready_mode = 0;
        issue(16'hAA45);  wait_idle();
        issue(16'h0000);  wait_idle();
        issue(16'h8000);  wait_idle();
        issue(16'hFFFF);  wait_idle();

        // Back-pressure while index 2 is presented
        stall_cnt  = 0;
        ready_mode = 2;
        issue(16'h0014);  wait_idle();
        ready_mode = 0;

        // start held from mid-extraction through the terminating edge
        issue(16'h0F0F);
        repeat (3) begin @(posedge clk); #1; end
        bus.start       = 1'b1;
        bus.truth_table = 16'h1234;
        n = 0;
        while (bus.busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) fail_now("timeout_restart");
        model_push(16'h1234);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset while a minterm is stalled in EMIT
        ready_mode = 3;
        issue(16'h0300);
        n = 0;
        while (!bus.m_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.m_valid) fail_now("timeout_emit");
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        q_exp.delete();
        q_done.delete();
        #1;
        check_all_zero("async_rst");
        repeat (2) begin @(posedge clk); #1; end
        check_all_zero("held_rst");
        rst_n      = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        issue(16'h0001);  wait_idle();

        // Randomized tables and consumer back-pressure
        for (int i = 0; i < 40; i++) begin
            ready_mode = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       tt = TW'($urandom);
                1:       tt = TW'($urandom) & TW'($urandom) & TW'($urandom);
                default: tt = TW'($urandom) | TW'($urandom);
            endcase
            issue(tt);
            wait_idle();
        end

        repeat (4) @(posedge clk);
        #1;
        check("left_minterms", q_exp.size(), 0);
        check("left_dones",    q_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
